inv_mix_column_iter: RTL and testbench

//  Iterative AES InvMixColumns for the decryption datapath; exact inverse of mix_column.

---
 rtl/inv_mix_column_iter.sv | 146 ++++++++++++++
 tb/tb_inv_mix_column_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_column_iter.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms COLS_PER_CYCLE
// columns per clock and returns the result over a valid/ready port with backpressure.
module inv_mix_column_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter step wraps to 0 when all four columns go in one pass.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using the x2/x4/x8 chain.
  function automatic logic [7:0] gf_mul_k(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [7:0] inv_row(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    return gf_mul_k(a, 4'he) ^ gf_mul_k(b, 4'hb) ^ gf_mul_k(c, 4'hd) ^ gf_mul_k(d, 4'h9);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    {b0, b1, b2, b3} = col;
    return {inv_row(b0, b1, b2, b3), inv_row(b1, b2, b3, b0),
            inv_row(b2, b3, b0, b1), inv_row(b3, b0, b1, b2)};
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;
  logic [1:0]     col_cnt_r;
  logic [127:0]   work_r;
  logic [127:0]   work_nxt_s;
  logic           last_grp_s;

  assign last_grp_s = (col_cnt_r == LAST_CNT);
  assign in_ready   = (state_r == ST_IDLE) & ~rst;
  assign busy       = (state_r != ST_IDLE);

  // Working state with the current column group replaced by its transform.
  always_comb begin
    work_nxt_s = work_r;
    for (int c = 0; c < 4; c++) begin
      if ((c >= int'(col_cnt_r)) && (c < int'(col_cnt_r) + COLS_PER_CYCLE)) begin
        work_nxt_s[127-32*c -: 32] = inv_mix_col(work_r[127-32*c -: 32]);
      end else begin
        work_nxt_s[127-32*c -: 32] = work_r[127-32*c -: 32];
      end
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_grp_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_r <= 2'd0;
      work_r    <= 128'd0;
      out_valid <= 1'b0;
      out_data  <= 128'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            work_r    <= in_data;
            col_cnt_r <= 2'd0;
          end
        end
        ST_RUN: begin
          work_r    <= work_nxt_s;
          col_cnt_r <= col_cnt_r + COL_STEP;
          if (last_grp_s) begin
            out_valid <= 1'b1;
            out_data  <= work_nxt_s;
          end
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_column_iter.sv
// Self-checking bench for inv_mix_column_iter: fixed vectors, handshake corner cases
// and random round trips through a GF(2^8) matrix model, for 1, 2 and 4 columns per cycle.
module tb_inv_mix_column_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst[3];
  logic         in_valid[3];
  logic         in_ready[3];
  logic [127:0] in_data[3];
  logic         out_valid[3];
  logic         out_ready[3];
  logic [127:0] out_data[3];
  logic         busy[3];

  inv_mix_column_iter #(.COLS_PER_CYCLE(1)) dut_c1 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]));
  inv_mix_column_iter #(.COLS_PER_CYCLE(2)) dut_c2 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]));
  inv_mix_column_iter #(.COLS_PER_CYCLE(4)) dut_c4 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]));

  int checks = 0;
  int failures = 0;
  int lat_tab[3] = '{4, 2, 1};

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // General GF(2^8) multiply, shift-and-add with reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column: r_i = sum_j coef[(j-i) mod 4] * b_j.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic [7:0] k0,
                                             input logic [7:0] k1, input logic [7:0] k2,
                                             input logic [7:0] k3);
    logic [7:0]   coef[4];
    logic [127:0] r = 128'd0;
    logic [7:0]   acc;
    coef = '{k0, k1, k2, k3};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - i + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        r[127 - 32*c - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic wait_ready(input int d, input string tag);
    int cyc = 0;
    while (!in_ready[d] && cyc < 20) begin tick(); cyc++; end
    chk1({tag, "_ready"}, in_ready[d], 1'b1);
  endtask

  task automatic run_vec(input int d, input logic [127:0] din, input logic [127:0] dexp,
                         input string tag);
    int cyc = 0;
    wait_ready(d, tag);
    in_valid[d] = 1'b1;
    in_data[d]  = din;
    tick();
    in_valid[d] = 1'b0;
    in_data[d]  = rand128();
    chk1({tag, "_busy"}, busy[d], 1'b1);
    chk1({tag, "_ready_low"}, in_ready[d], 1'b0);
    while (!out_valid[d] && cyc < 20) begin tick(); cyc++; end
    chk({tag, "_latency"}, 128'(cyc), 128'(lat_tab[d]));
    chk({tag, "_data"}, out_data[d], dexp);
    tick();
    chk1({tag, "_valid_clr"}, out_valid[d], 1'b0);
    chk1({tag, "_ready_back"}, in_ready[d], 1'b1);
    chk1({tag, "_idle"}, busy[d], 1'b0);
  endtask

  task automatic backpressure(input int d);
    int cyc = 0;
    out_ready[d] = 1'b0;
    wait_ready(d, "bp");
    in_valid[d] = 1'b1;
    in_data[d]  = vecs[0].din;
    tick();
    in_valid[d] = 1'b0;
    while (!out_valid[d] && cyc < 20) begin tick(); cyc++; end
    chk1("bp_valid", out_valid[d], 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = rand128();
      tick();
      chk1("bp_hold_valid", out_valid[d], 1'b1);
      chk("bp_hold_data", out_data[d], vecs[0].dexp);
      chk1("bp_hold_ready", in_ready[d], 1'b0);
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    tick();
    chk1("bp_release_valid", out_valid[d], 1'b0);
    chk1("bp_release_ready", in_ready[d], 1'b1);
    tick();
    chk1("bp_single_hs", out_valid[d], 1'b0);
  endtask

  task automatic reset_mid(input int d);
    wait_ready(d, "rm");
    in_valid[d] = 1'b1;
    in_data[d]  = vecs[0].din;
    tick();
    in_valid[d] = 1'b0;
    tick();
    rst[d] = 1'b1;
    #1;
    chk1("rm_ready_in_rst", in_ready[d], 1'b0);
    tick();
    rst[d] = 1'b0;
    #1;
    chk1("rm_ready_after", in_ready[d], 1'b1);
    chk1("rm_busy_after", busy[d], 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk1("rm_no_valid", out_valid[d], 1'b0);
      tick();
    end
    run_vec(d, vecs[0].din, vecs[0].dexp, "rm_recover");
  endtask

  // Back-to-back random states; input = MixColumns(orig), expected output = orig.
  task automatic stream(input int d, input int n);
    logic [127:0] q[$];
    logic [127:0] orig;
    int sent = 0;
    int rcv = 0;
    int last_acc = -1;
    int cyc = 0;
    int bound = n * (lat_tab[d] + 2) + 40;
    out_ready[d] = 1'b1;
    while (rcv < n && cyc < bound) begin
      if (out_valid[d]) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra: got %h expected no output", out_data[d]);
        end else begin
          chk("stream_roundtrip", out_data[d], q.pop_front());
        end
        rcv++;
      end
      if (in_ready[d] && sent < n) begin
        orig        = rand128();
        in_valid[d] = 1'b1;
        in_data[d]  = mix_model(orig, 8'h02, 8'h03, 8'h01, 8'h01);
        q.push_back(orig);
        if (last_acc >= 0) chk("stream_gap", 128'(cyc - last_acc), 128'(lat_tab[d] + 2));
        last_acc = cyc;
        sent++;
      end else begin
        in_valid[d] = (sent < n);
        in_data[d]  = rand128();
      end
      tick();
      cyc++;
    end
    in_valid[d] = 1'b0;
    chk("stream_count", 128'(rcv), 128'(n));
  endtask

  initial begin
    vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'hdb135345_f20a225c_01010101_d4d4d4d5};
    vecs[1] = '{128'hc6c6c6c6_01010101_c6c6c6c6_01010101, 128'hc6c6c6c6_01010101_c6c6c6c6_01010101};
    vecs[2] = '{128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8, 128'h2d26314c_2d26314c_2d26314c_2d26314c};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = 128'd0; out_ready[d] = 1'b1;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk1("reset_in_ready", in_ready[d], 1'b0);
      chk1("reset_out_valid", out_valid[d], 1'b0);
      chk("reset_out_data", out_data[d], 128'd0);
      chk1("reset_busy", busy[d], 1'b0);
      rst[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) chk1("reset_release_ready", in_ready[d], 1'b1);

    for (int d = 0; d < 3; d++)
      for (int v = 0; v < 3; v++)
        run_vec(d, vecs[v].din, vecs[v].dexp, $sformatf("vec%0d_c%0d", v, d));

    backpressure(0);
    reset_mid(0);
    reset_mid(1);

    stream(0, 1000);
    stream(1, 200);
    stream(2, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
